// File: rtl/seq_add_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_add_pkg                                            |
// | Description : State encoding and saturation constants for seq_add.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package seq_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Largest positive two's-complement value for a w-bit word (w <= 64).
    function automatic logic [63:0] max_of(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value for a w-bit word (w <= 64).
    function automatic logic [63:0] min_of(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_add_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : full_adder / add_slice                                 |
// | Description : One-bit full adder and a DIGIT-bit ripple chain of it. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);
    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;
    assign cout   = w_c[DIGIT];

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .sum  (sum[i]),
            .cout (w_c[i+1])
        );
    end
endmodule
`default_nettype wire

// File: rtl/seq_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_add                                                |
// | Description : Multi-cycle add/sub, DIGIT bits per clock, LSB first.  |
// |               Define SEQ_ADD_SAT_EN to enable saturation on overflow.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seq_add
    import seq_add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int             c_n   = WIDTH / DIGIT;
    localparam int             c_cw  = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [WIDTH-1:0] c_max = WIDTH'(max_of(WIDTH));
    localparam logic [WIDTH-1:0] c_min = WIDTH'(min_of(WIDTH));

`ifdef SEQ_ADD_SAT_EN
    localparam logic c_sat_allow = 1'b1;
`else
    localparam logic c_sat_allow = 1'b0;
`endif

    state_t            r_state, w_next;
    logic [WIDTH-1:0]  r_a, r_b;
    logic              r_carry;
    logic [c_cw-1:0]   r_cnt;
    logic              r_amsb, r_bmsb, r_sat;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout, r_ovf, r_zero, r_neg;

    logic [DIGIT-1:0]  w_ssum;
    logic              w_scout;
    logic              w_last;
    logic [WIDTH-1:0]  w_final, w_outsum;
    logic              w_ovf, w_clamp;

    add_slice #(.DIGIT(DIGIT)) u_slice (
        .a    (r_a[DIGIT-1:0]),
        .b    (r_b[DIGIT-1:0]),
        .cin  (r_carry),
        .sum  (w_ssum),
        .cout (w_scout)
    );

    assign w_last = (r_cnt == c_cw'(c_n - 1));

    // Slices 0..N-2 are parked here; the last slice joins them straight from the adder.
    if (c_n == 1) begin : g_single
        assign w_final = w_ssum;
    end else begin : g_multi
        logic [WIDTH-DIGIT-1:0] r_res;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_res <= '0;
            end else if (r_state == ST_RUN) begin
                for (int k = 0; k < c_n - 1; k++) begin
                    if (r_cnt == c_cw'(k)) r_res[k*DIGIT +: DIGIT] <= w_ssum;
                end
            end
        end

        assign w_final = {w_ssum, r_res};
    end

    assign w_ovf    = (r_amsb == r_bmsb) & (w_final[WIDTH-1] != r_amsb);
    assign w_clamp  = w_ovf & r_sat & c_sat_allow;
    assign w_outsum = w_clamp ? (r_amsb ? c_min : c_max) : w_final;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            r_sat   <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= cin ^ sub;
                        r_cnt   <= '0;
                        r_amsb  <= a[WIDTH-1];
                        r_bmsb  <= b[WIDTH-1] ^ sub;
                        r_sat   <= sat;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_scout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum  <= w_outsum;
                        r_cout <= w_scout;
                        r_ovf  <= w_ovf;
                        r_zero <= (w_outsum == '0);
                        r_neg  <= w_outsum[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;
    assign neg  = r_neg;
endmodule
`default_nettype wire

// File: tb/tb_seq_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_seq_add                                             |
// | Description : Self-checking bench for seq_add at DIGIT = 4, 1, 16.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_seq_add;
    localparam int c_nd = 3;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, sub, cin, sat, out_ready;
    logic [15:0] a, b;

    logic [c_nd-1:0] ov_ready, ov_valid, ov_cout, ov_ovf, ov_zero, ov_neg;
    logic [15:0]     ov_sum [c_nd];

    int n_tests = 0;
    int n_fail  = 0;

    int          lat   [c_nd];
    logic [15:0] r_sum [c_nd];
    logic        r_co  [c_nd];
    logic        r_ov  [c_nd];
    logic        r_z   [c_nd];
    logic        r_n   [c_nd];
    int          exp_lat [c_nd] = '{4, 16, 1};

    always #5 clk = ~clk;

    seq_add #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ov_ready[0]),
        .a(a), .b(b), .sub(sub), .cin(cin), .sat(sat),
        .out_valid(ov_valid[0]), .out_ready(out_ready), .sum(ov_sum[0]),
        .cout(ov_cout[0]), .ovf(ov_ovf[0]), .zero(ov_zero[0]), .neg(ov_neg[0]));

    seq_add #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ov_ready[1]),
        .a(a), .b(b), .sub(sub), .cin(cin), .sat(sat),
        .out_valid(ov_valid[1]), .out_ready(out_ready), .sum(ov_sum[1]),
        .cout(ov_cout[1]), .ovf(ov_ovf[1]), .zero(ov_zero[1]), .neg(ov_neg[1]));

    seq_add #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ov_ready[2]),
        .a(a), .b(b), .sub(sub), .cin(cin), .sat(sat),
        .out_valid(ov_valid[2]), .out_ready(out_ready), .sum(ov_sum[2]),
        .cout(ov_cout[2]), .ovf(ov_ovf[2]), .zero(ov_zero[2]), .neg(ov_neg[2]));

    typedef struct {
        logic [15:0] a, b;
        logic        sub, cin, sat;
        logic [15:0] e_sum;
        logic        e_cout, e_ovf, e_zero, e_neg;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Signed-range arithmetic model, independent of slice/carry mechanics.
    task automatic model(input logic [15:0] ma, mb, input logic ms, mc, msat,
                         output logic [15:0] s, output logic co, ov);
        int u, r;
        if (!ms) begin
            u  = int'(ma) + int'(mb) + int'(mc);
            r  = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
            co = (u > 65535);
        end else begin
            u  = int'(ma) - int'(mb) - int'(mc);
            r  = int'($signed(ma)) - int'($signed(mb)) - int'(mc);
            co = (u >= 0);
        end
        s  = u[15:0];
        ov = (r > 32767) || (r < -32768);
`ifdef SEQ_ADD_SAT_EN
        if (msat && ov) s = ma[15] ? 16'h8000 : 16'h7FFF;
`endif
    endtask

    // Issue one operation to all DUTs and capture each result with its latency.
    task automatic run_op(input logic [15:0] ta, tb, input logic ts, tc, tsat);
        bit got [c_nd];
        int k;
        chk("idle_before_op", 32'(ov_ready), 32'h7);
        a = ta; b = tb; sub = ts; cin = tc; sat = tsat; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        for (int i = 0; i < c_nd; i++) got[i] = 1'b0;
        k = 0;
        while (!(got[0] && got[1] && got[2]) && k < 40) begin
            for (int i = 0; i < c_nd; i++) begin
                if (ov_valid[i] && !got[i]) begin
                    got[i] = 1'b1; lat[i] = k;
                    r_sum[i] = ov_sum[i]; r_co[i] = ov_cout[i]; r_ov[i] = ov_ovf[i];
                    r_z[i] = ov_zero[i]; r_n[i] = ov_neg[i];
                end
            end
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < c_nd; i++) begin
            if (!got[i]) begin
                n_tests++; n_fail++;
                $display("FAIL timeout dut%0d: no out_valid within 40 cycles", i);
                lat[i] = -1;
            end
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] es, input logic eco, eov, ez, en);
        for (int i = 0; i < c_nd; i++) begin
            chk($sformatf("%s.lat%0d", tag, i),  32'(lat[i]), 32'(exp_lat[i]));
            chk($sformatf("%s.sum%0d", tag, i),  32'(r_sum[i]), 32'(es));
            chk($sformatf("%s.cout%0d", tag, i), 32'(r_co[i]), 32'(eco));
            chk($sformatf("%s.ovf%0d", tag, i),  32'(r_ov[i]), 32'(eov));
            chk($sformatf("%s.zero%0d", tag, i), 32'(r_z[i]), 32'(ez));
            chk($sformatf("%s.neg%0d", tag, i),  32'(r_n[i]), 32'(en));
        end
    endtask

    initial begin
        vec_t        vt [10];
        logic [15:0] hs, ms;
        logic        mco, mov, msat_bit;
        logic [15:0] corner [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};

        vt[0] = '{16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 0, 1, 0, 1};
        vt[1] = '{16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 0, 1, 0};
        vt[2] = '{16'hAAAA, 16'h5555, 0, 0, 0, 16'hFFFF, 0, 0, 0, 1};
        vt[3] = '{16'h0005, 16'h0007, 1, 0, 0, 16'hFFFE, 0, 0, 0, 1};
        vt[4] = '{16'h8000, 16'h0001, 1, 0, 0, 16'h7FFF, 1, 1, 0, 0};
        vt[5] = '{16'h0002, 16'h0002, 1, 1, 0, 16'hFFFF, 0, 0, 0, 1};
        vt[6] = '{16'h0000, 16'h0000, 0, 1, 0, 16'h0001, 0, 0, 0, 0};
        vt[7] = '{16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 1, 0};
`ifdef SEQ_ADD_SAT_EN
        vt[8] = '{16'h7FFF, 16'h0001, 0, 0, 1, 16'h7FFF, 0, 1, 0, 0};
        vt[9] = '{16'h8000, 16'h0001, 1, 0, 1, 16'h8000, 1, 1, 0, 1};
`else
        vt[8] = '{16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000, 0, 1, 0, 1};
        vt[9] = '{16'h8000, 16'h0001, 1, 0, 1, 16'h7FFF, 1, 1, 0, 0};
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0; sat = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < c_nd; i++) begin
            chk($sformatf("rst.sum%0d", i), 32'(ov_sum[i]), 32'h0);
        end
        chk("rst.in_ready",  32'(ov_ready), 32'h7);
        chk("rst.out_valid", 32'(ov_valid), 32'h0);
        chk("rst.flags",     32'({ov_cout, ov_ovf, ov_zero, ov_neg}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            run_op(vt[v].a, vt[v].b, vt[v].sub, vt[v].cin, vt[v].sat);
            check_all($sformatf("vec%0d", v), vt[v].e_sum, vt[v].e_cout, vt[v].e_ovf,
                      vt[v].e_zero, vt[v].e_neg);
        end

        // Backpressure: result must hold while out_ready is low, new requests ignored.
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h0101; sub = 1'b0; cin = 1'b0; sat = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (18) begin @(posedge clk); @(negedge clk); end
        hs = ov_sum[0];
        chk("bp.sum", 32'(hs), 32'h1335);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin a = 16'h0F00; b = 16'h00F0; in_valid = 1'b1; end
            else in_valid = 1'b0;
            chk($sformatf("bp.hold%0d", c), 32'(ov_sum[0]), 32'(hs));
            chk($sformatf("bp.valid%0d", c), 32'(ov_valid), 32'h7);
            chk($sformatf("bp.ready%0d", c), 32'(ov_ready), 32'h0);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp.release_ready", 32'(ov_ready), 32'h7);
        chk("bp.release_valid", 32'(ov_valid), 32'h0);
        chk("bp.sum_after",     32'(ov_sum[0]), 32'h1335);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("bp.pulse_ignored", 32'(ov_ready), 32'h7);

        // Reset during the second RUN cycle aborts the operation.
        a = 16'h0F0F; b = 16'h0101; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst.sum",       32'(ov_sum[0]), 32'h0);
        chk("mrst.flags",     32'({ov_cout, ov_ovf, ov_zero, ov_neg}), 32'h0);
        chk("mrst.in_ready",  32'(ov_ready), 32'h7);
        chk("mrst.out_valid", 32'(ov_valid), 32'h0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (20) begin
                @(posedge clk);
                @(negedge clk);
                seen = seen | (|ov_valid);
            end
            chk("mrst.no_result", 32'(seen), 32'h0);
        end
        run_op(16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0);
        check_all("mrst.next", 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 1000; t++) begin
            logic [15:0] ra, rb;
            logic        rs, rc;
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
            rs = 1'($urandom); rc = 1'($urandom); msat_bit = 1'($urandom);
            model(ra, rb, rs, rc, msat_bit, ms, mco, mov);
            run_op(ra, rb, rs, rc, msat_bit);
            check_all($sformatf("rnd%0d", t), ms, mco, mov, (ms == 16'h0), ms[15]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
`default_nettype wire
